alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Downstream stage of the ALU top level. Captures every result the ALU produces (result word, 4-bit flag vector, and the operation code that produced it) into a DEPTH-entry first-word-fall-through FIFO, which presents it to a consumer through a valid/ready handshake. Also keeps saturating statistics counters for the ERR and OVERFLOW flags, and a sticky drop indicator for words lost while the FIFO was full.

## Interface
Parameters:
- WIDTH, 4: ALU data width; must match the ALU's WIDTH.
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- CNT_W, 8: width of each statistics counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  ALU word on i_result/i_flag/i_oper is valid this cycle.
- i_result  in  WIDTH  ALU o_result.
- i_flag  in  4  ALU o_flag: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.
- i_oper  in  2  operation code that produced the word: 00 subtract, 01 nand, 10 starting_ones, 11 onehot decoder.
- o_ready  out  1  FIFO can accept a word this cycle.
- o_valid  out  1  head word present on o_result/o_flag/o_oper.
- i_ready  in  1  consumer accepts the head word this cycle.
- o_result  out  WIDTH  head result.
- o_flag  out  4  head flags.
- o_oper  out  2  head operation code.
- o_count  out  $clog2(DEPTH)+1  number of stored words.
- o_err_cnt  out  CNT_W  accepted words with ERR=1, saturating.
- o_ovf_cnt  out  CNT_W  accepted words with OVERFLOW=1, saturating.
- o_drop  out  1  sticky: at least one word was offered while the FIFO was full.
- i_clr_stats  in  1  clears o_err_cnt, o_ovf_cnt, o_drop.

## Operation
- Storage: DEPTH × (WIDTH+4+2) array, plus read/write pointers of width $clog2(DEPTH)+1 (wrap bit included). full = pointers equal except the MSB; empty = pointers equal.
- Push: i_valid && o_ready writes {i_result, i_flag, i_oper} at the write pointer, and the write pointer increments.
- Pop: o_valid && i_ready advances the read pointer.
- o_ready = !full && !i_rst (combinational).
- o_valid = !empty (combinational from registered pointers).
- o_result/o_flag/o_oper are read combinationally from the entry at the read pointer. They are don't-care while o_valid=0.
- o_count = wr_ptr − rd_ptr, computed modulo 2^(ptr width).
- Pointer wrap: the index uses the low $clog2(DEPTH) bits, and the MSB toggles on wrap. No special case is needed at DEPTH−1 → 0.
- Simultaneous push and pop while neither full nor empty: both occur, and o_count is unchanged.
- Push while full: rejected even if a pop occurs in the same cycle. The word is lost, o_drop is set, and the counters are not incremented.
- Pop while empty: ignored.
- Push while empty: the word becomes visible on the next cycle. There is no same-cycle bypass.
- Statistics: on an accepted push, o_err_cnt increments if i_flag[0]=1 and o_ovf_cnt increments if i_flag[3]=1. Each counter holds at 2^CNT_W−1.
- Stats clear: i_clr_stats=1 zeroes both counters and o_drop. Clear wins over any same-cycle increment or drop event (that event is lost). FIFO contents are unaffected.
- Reset, including mid-operation: both pointers go to 0 (FIFO emptied, contents discarded), counters go to 0, and o_drop goes to 0. Reset overrides any push, pop or clear in the same cycle.

## Timing
- Reset values, after the first edge with i_rst=1:
  - o_valid=0, o_count=0, o_err_cnt=0, o_ovf_cnt=0, o_drop=0.
  - o_ready=0 while i_rst=1; o_ready=1 in the first cycle after release.
  - o_result/o_flag/o_oper are don't-care.
- Latency: a word pushed at edge k is valid on the outputs after edge k (1 cycle from i_valid to o_valid).
- Throughput: one push and one pop per cycle, sustained.
- o_count, counters and o_drop update on the same edge as the push/pop/clear that causes them.
- o_ready depends only on registered state and i_rst. There is no combinational path from i_ready to o_ready.

## Test plan
- Reset mid-stream: push 3 words, assert i_rst for 1 cycle → o_count=0, o_valid=0, o_ready=0 during reset and 1 after; the counters read 0.
- Ordering through wrap:
  - Stimulus (DEPTH=8): push 12 words with i_result=0..11 while popping with i_ready=1 from cycle 3.
  - Required response: outputs are 0..11 in order, no drops, o_count never exceeds 8.
- Full boundary:
  - Stimulus: with i_ready=0, push 9 words.
  - Required response: o_count=8 and o_ready=0 after the 8th push; o_drop=1 after the 9th; then 8 pops return only the first 8 words.
- Simultaneous push and pop when full: push and pop in the same cycle → pop occurs, push is dropped, o_count=7, o_drop=1.
- Statistics:
  - Stimulus: push 5 words with i_flag=4'b1001, then 2 words with 4'b0001.
  - Required response: o_err_cnt=7, o_ovf_cnt=5.
  - Then: assert i_clr_stats in the same cycle as a push with 4'b0001 → o_err_cnt=0.
- Saturation: with CNT_W=2, push 6 words with ERR=1 → o_err_cnt holds at 3.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Result capture FIFO behind the ALU: first-word-fall-through storage of {result, flags, op}
// with a valid/ready consumer port, saturating ERR/OVERFLOW counters and a sticky drop flag.
module alu_result_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_result,
    input  logic [3:0]               i_flag,
    input  logic [1:0]               i_oper,
    output logic                     o_ready,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_result,
    output logic [3:0]               o_flag,
    output logic [1:0]               o_oper,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic [CNT_W-1:0]         o_ovf_cnt,
    output logic                     o_drop,
    input  logic                     i_clr_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + 6;
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a word moves on any edge where its producer's valid and its
    // consumer's ready are both high; valid never waits on ready.
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic             drop_q, drop_d;
    logic             full, empty, push, pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign o_ready = !full && !i_rst;
    assign o_valid = !empty;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    assign {o_result, o_flag, o_oper} = mem_q[rd_ptr_q[AW-1:0]];
    assign o_count   = wr_ptr_q - rd_ptr_q;
    assign o_err_cnt = err_cnt_q;
    assign o_ovf_cnt = ovf_cnt_q;
    assign o_drop    = drop_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        drop_d    = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        // A clear discards any statistics event arriving in the same cycle.
        if (i_clr_stats) begin
            err_cnt_d = '0;
            ovf_cnt_d = '0;
            drop_d    = 1'b0;
        end else begin
            if (push && i_flag[0] && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_ONE;
            if (push && i_flag[3] && (ovf_cnt_q != CNT_MAX)) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            if (i_valid && full) drop_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Storage carries no reset; push is already blocked while i_rst is high.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {i_result, i_flag, i_oper};
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model; a second instance with 2-bit counters covers saturation.
module tb_alu_result_buffer;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst, valid, ready, clr;
    logic [WIDTH-1:0] result;
    logic [3:0] flag;
    logic [1:0] oper;

    logic o_ready, o_valid, o_drop;
    logic [WIDTH-1:0] o_result;
    logic [3:0] o_flag;
    logic [1:0] o_oper;
    logic [3:0] o_count;
    logic [7:0] o_err_cnt, o_ovf_cnt;

    logic s_ready, s_valid, s_drop;
    logic [WIDTH-1:0] s_result;
    logic [3:0] s_flag;
    logic [1:0] s_oper;
    logic [3:0] s_count;
    logic [1:0] s_err_cnt, s_ovf_cnt;

    logic [WIDTH+5:0] exp_q[$];
    int err_n, ovf_n;
    logic drop_m;
    int n_vec, n_err;

    always #5 clk = ~clk;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_result(result), .i_flag(flag),
        .i_oper(oper), .o_ready(o_ready), .o_valid(o_valid), .i_ready(ready),
        .o_result(o_result), .o_flag(o_flag), .o_oper(o_oper), .o_count(o_count),
        .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt), .o_drop(o_drop), .i_clr_stats(clr)
    );

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_result(result), .i_flag(flag),
        .i_oper(oper), .o_ready(s_ready), .o_valid(s_valid), .i_ready(ready),
        .o_result(s_result), .o_flag(s_flag), .o_oper(s_oper), .o_count(s_count),
        .o_err_cnt(s_err_cnt), .o_ovf_cnt(s_ovf_cnt), .o_drop(s_drop), .i_clr_stats(clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int sat(input int n, input int cap);
        return (n > cap) ? cap : n;
    endfunction

    // Compare outputs mid-cycle, then advance the model by what this cycle's inputs do.
    task automatic step();
        bit is_full, is_empty, do_pop, do_push;
        @(negedge clk);
        is_full  = (exp_q.size() == DEPTH);
        is_empty = (exp_q.size() == 0);
        check("count", 64'(o_count), 64'(exp_q.size()));
        check("valid", 64'(o_valid), 64'(!is_empty));
        check("ready", 64'(o_ready), 64'(!is_full && !rst));
        if (!is_empty) check("head", 64'({o_result, o_flag, o_oper}), 64'(exp_q[0]));
        check("err_cnt", 64'(o_err_cnt), 64'(sat(err_n, 255)));
        check("ovf_cnt", 64'(o_ovf_cnt), 64'(sat(ovf_n, 255)));
        check("drop", 64'(o_drop), 64'(drop_m));
        check("sat_err_cnt", 64'(s_err_cnt), 64'(sat(err_n, 3)));
        check("sat_ovf_cnt", 64'(s_ovf_cnt), 64'(sat(ovf_n, 3)));
        if (rst) begin
            exp_q.delete();
            err_n = 0; ovf_n = 0; drop_m = 1'b0;
        end else begin
            do_pop  = !is_empty && ready;
            do_push = valid && !is_full;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({result, flag, oper});
            if (clr) begin
                err_n = 0; ovf_n = 0; drop_m = 1'b0;
            end else begin
                if (do_push && flag[0]) err_n++;
                if (do_push && flag[3]) ovf_n++;
                if (valid && is_full) drop_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] f,
                         input logic [1:0] op, input logic rdy, input logic c, input logic rs);
        valid = v; result = r; flag = f; oper = op; ready = rdy; clr = c; rst = rs;
        step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; err_n = 0; ovf_n = 0; drop_m = 1'b0;
        valid = 0; result = 0; flag = 0; oper = 0; ready = 0; clr = 0; rst = 1;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) drive(1, 4'(i + 5), 4'b1001, 2'(i), 0, 0, 0);
        drive(1, 4'hf, 4'b0001, 2'd3, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Ordering through pointer wrap
        for (int i = 0; i < 12; i++) drive(1, 4'(i), 4'(i), 2'(i), (i >= 2), 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 0, 0);

        // Full boundary, then push+pop while full
        for (int i = 0; i < 9; i++) drive(1, 4'(i + 3), 4'b0100, 2'd1, 0, 0, 0);
        drive(1, 4'hc, 4'b0010, 2'd2, 1, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 1, 0, 0);

        // Statistics and clear-wins
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 4'(i), 4'b1001, 2'd0, 1, 0, 0);
        for (int i = 0; i < 2; i++) drive(1, 4'(i), 4'b0001, 2'd3, 1, 0, 0);
        drive(1, 4'h9, 4'b0001, 2'd1, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0);

        // Saturation on the 2-bit instance
        for (int i = 0; i < 6; i++) drive(1, 4'(i), 4'b1001, 2'd2, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0) ^ (i >= 200),
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
        end
        drive(0, 0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
